// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM bridge: FSM states, beat-count helper
// and the idle level of the active-low SRAM strobes.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic STROBE_OFF = 1'b1;

    function automatic int beats(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

endpackage

// File: rtl/sram_beat_counter.sv
// Wait-cycle and beat sequencing for one SRAM access: each beat lasts
// WAIT_CYCLES+1 enabled cycles, and the access ends after BEATS beats.
module sram_beat_counter #(
    parameter int BEATS       = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int BW          = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [BW-1:0] beat_o,
    output logic          beat_last_o,
    output logic          access_last_o
);

    logic [3:0]    wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;

    assign beat_o        = beat_q;
    assign beat_last_o   = (wait_q == 4'(WAIT_CYCLES));
    assign access_last_o = beat_last_o && (beat_q == BW'(BEATS - 1));

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the branches below can leave it unassigned and infer a latch.
    always_comb begin
        wait_d = wait_q;
        beat_d = beat_q;
        if (clear_i) begin
            wait_d = '0;
            beat_d = '0;
        end else if (en_i) begin
            if (beat_last_o) begin
                wait_d = '0;
                beat_d = access_last_o ? '0 : beat_q + BW'(1);
            end else begin
                wait_d = wait_q + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            beat_q <= '0;
        end else begin
            wait_q <= wait_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/sram_bridge.sv
// MEM-stage to asynchronous SRAM bridge: splits a DATA_W load/store into
// little-endian SRAM_DW beats with programmable wait states, freezing the pipeline.
module sram_bridge
    import sram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic               read_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  writeData,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int BEATS = beats(DATA_W, SRAM_DW);
    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e              state_q, state_d;
    logic [SRAM_AW-1:0]  base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_write_q, is_write_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;

    logic                counter_clear;
    logic                in_access;
    logic [BW-1:0]       beat;
    logic                beat_last;
    logic                access_last;
    int                  beat_ofs;

    assign in_access = (state_q == ST_ACCESS);
    assign beat_ofs  = int'(beat) * SRAM_DW;

    sram_beat_counter #(
        .BEATS       (BEATS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BW          (BW)
    ) u_beat_counter (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (counter_clear),
        .en_i          (in_access),
        .beat_o        (beat),
        .beat_last_o   (beat_last),
        .access_last_o (access_last)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        is_write_d    = is_write_q;
        rbuf_d        = rbuf_q;
        read_data_d   = read_data_q;
        counter_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (write_en || read_en) begin
                    state_d       = ST_ACCESS;
                    counter_clear = 1'b1;
                    // First SRAM word of the access; wraps modulo 2^SRAM_AW.
                    base_d        = SRAM_AW'(((address - 32'(BASE_ADDR)) >> SHIFT) * 32'(BEATS));
                    wdata_d       = writeData;
                    is_write_d    = write_en;
                end
            end
            ST_ACCESS: begin
                if (!is_write_q && beat_last) begin
                    rbuf_d[beat_ofs +: SRAM_DW] = SRAM_DQ;
                end
                if (access_last) begin
                    state_d = ST_DONE;
                    // Commit the whole word at once so read_data never shows a half-loaded value.
                    if (!is_write_q) begin
                        read_data_d = rbuf_d;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            rbuf_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            rbuf_q      <= rbuf_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;
    assign ready     = !(((state_q == ST_IDLE) && (write_en || read_en)) || in_access);

    assign SRAM_ADDR = in_access ? base_q + SRAM_AW'(beat) : '0;
    assign SRAM_CE_N = in_access ? 1'b0 : STROBE_OFF;
    assign SRAM_UB_N = in_access ? 1'b0 : STROBE_OFF;
    assign SRAM_LB_N = in_access ? 1'b0 : STROBE_OFF;
    assign SRAM_OE_N = (in_access && !is_write_q) ? 1'b0 : STROBE_OFF;
    // The last cycle of each beat releases WE_N so the SRAM latches on its rising edge.
    assign SRAM_WE_N = (in_access && is_write_q && ((WAIT_CYCLES == 0) || !beat_last))
                       ? 1'b0 : STROBE_OFF;
    assign SRAM_DQ   = (in_access && is_write_q) ? wdata_q[beat_ofs +: SRAM_DW] : 'z;

endmodule
